int_sched: RTL and testbench
============================

// Module: int_sched
// PURPOSE
//  Interrupt scheduler in front of the interrupt context stack. Captures irq edges, picks the highest-priority
//  eligible request, and handshakes with AP_ctrl at an instruction boundary. Sequences the stack's int_set
//  (push) and ret_valid (pop) strobes and tracks nesting depth and the active-priority chain.
//  Issues the handler vector address. Lower irq index = higher priority.
// PARAMETERS
//  NUM_IRQ        4        number of interrupt request lines
//  ID_WIDTH       2        width of interrupt id, clog2(NUM_IRQ)
//  STACK_DEPTH    8        max nesting; must equal context-stack depth
//  DEPTH_WIDTH    4        width of depth counter, holds 0..STACK_DEPTH
//  ADDR_WIDTH_MEM 16       instruction address width
//  VEC_BASE       16'h0100 vector of irq 0
//  VEC_STRIDE     16'h0010 vector spacing per id
// PORTS
//  clk        in  1               system clock, all logic on rising edge
//  rst        in  1               asynchronous, active-low reset
//  irq        in  NUM_IRQ         interrupt request lines, rising-edge sensitive
//  irq_mask   in  NUM_IRQ         1 = line masked (pending kept, not eligible)
//  int_en     in  1               global enable; 0 blocks new acceptance only
//  int_ack    in  1               AP_ctrl: at boundary, accept offered interrupt
//  iret       in  1               AP_ctrl: return-from-interrupt executed (1-cycle pulse)
//  ctxt_rdy   in  1               context stack: restored context valid
//  int_req    out 1               interrupt offered to AP_ctrl
//  int_id     out ID_WIDTH        id being offered / pushed
//  int_set    out 1               push strobe to context stack
//  ret_valid  out 1               pop strobe to context stack
//  vec_valid  out 1               1-cycle: vec_addr valid, AP_ctrl jumps
//  vec_addr   out ADDR_WIDTH_MEM  VEC_BASE + int_id*VEC_STRIDE (ADDR_WIDTH_MEM bits, wraps)
//  ret_done   out 1               1-cycle: return complete, context restored
//  depth      out DEPTH_WIDTH     current nesting depth
//  busy       out 1               state != IDLE
//  err_unf    out 1               sticky: iret seen with depth==0
// BEHAVIOUR
//  Reset: all outputs 0; pend=0; depth=0; active chain cleared; irq edge history=0; state IDLE.
//   Reset mid-sequence aborts immediately, no strobe completes.
//  Pending: pend[i] set when irq[i] rises (registered history). Cleared in PUSH for the accepted id.
//   A re-edge while pending is absorbed.
//  Eligible: pend & ~irq_mask, int_en=1, depth<STACK_DEPTH, and (depth==0 or id < act_id[depth-1]).
//   act_id[] is the id-per-level register array; equal or lower priority never preempts.
//  FSM states: IDLE, REQ, PUSH, VEC, POP, WAIT_CTXT, DONE.
//   IDLE: iret has priority over a new interrupt in the same cycle.
//     iret & depth==0 -> set err_unf, pulse ret_done next cycle via DONE, no ret_valid.
//     iret & depth>0 -> POP.
//     Otherwise eligible -> latch lowest eligible index into int_id, go REQ.
//   REQ: int_req=1; int_id frozen even if higher irq arrives; wait int_ack -> PUSH.
//     If the latched line becomes masked/disabled before ack: drop int_req, return IDLE.
//   PUSH: int_set=1 exactly one cycle; clear pend[int_id]; act_id[depth]<=int_id; depth++ -> VEC.
//   VEC: int_set=0; vec_valid=1 one cycle -> IDLE. Push-to-push gap >=3 cycles (stack edge-detect safe).
//   POP: ret_valid=1 one cycle; depth-- -> WAIT_CTXT.
//   WAIT_CTXT: ret_valid=0; wait ctxt_rdy=1 (no timeout) -> DONE.
//   DONE: ret_done=1 one cycle -> IDLE.
//  Latency: int_ack -> int_set next cycle -> vec_valid one cycle later. iret -> ret_valid next cycle.
//  Full: depth==STACK_DEPTH blocks acceptance; pend retained, served after returns.
//  iret outside IDLE is ignored (AP_ctrl never issues it while busy).
//  irq edges are captured in every state, including during PUSH of another id.
// TESTING
//  1 irq[2] rises, mask=0, int_en=1 -> int_req, int_id=2.
//    int_ack -> int_set 1 cycle, then vec_valid with vec_addr=16'h0120, depth=1.
//  2 Nesting: in irq2 handler, irq[1] and irq[3] rise -> irq1 taken (depth=2), irq3 stays pend.
//    iret -> ret_valid, ctxt_rdy, ret_done, depth=1; irq3 still not offered.
//    iret -> depth=0 -> irq3 offered.
//  3 Same cycle iret and eligible irq[0] at depth=1 -> ret_valid first; irq0 offered after ret_done.
//  4 Push 8 nested ids (descending priority) -> depth=8.
//    Further eligible irq: no int_req until one iret completes.
//  5 iret at depth=0 -> err_unf=1 sticky, ret_done pulse, ret_valid never asserted.
//  6 REQ for id 3, set irq_mask[3]=1 before ack -> int_req drops, IDLE, pend[3] kept.
//    Unmask -> re-offered. Then rst low mid-WAIT_CTXT -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/int_sched.sv
// int_sched: captures irq edges, offers the highest-priority eligible request to AP_ctrl,
//            and sequences the context-stack push (int_set) and pop (ret_valid) strobes.
// Latency:   int_ack -> int_set next cycle -> vec_valid the cycle after.
//            iret -> ret_valid next cycle.
// Backpressure: REQ holds until int_ack. WAIT_CTXT holds until ctxt_rdy, with no timeout.
// Ports: clk_i/rst_ni (async, active-low); irq_i/irq_mask_i/int_en_i request side;
//        int_ack_i/iret_i from AP_ctrl; ctxt_rdy_i from stack; int_req_o/int_id_o offer;
//        int_set_o/ret_valid_o stack strobes; vec_valid_o/vec_addr_o jump target;
//        ret_done_o return complete; depth_o nesting; busy_o; err_unf_o sticky underflow.
module int_sched #(
  parameter int NUM_IRQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int STACK_DEPTH    = 8,
  parameter int DEPTH_WIDTH    = 4,
  parameter int ADDR_WIDTH_MEM = 16,
  parameter logic [ADDR_WIDTH_MEM-1:0] VEC_BASE   = 16'h0100,
  parameter logic [ADDR_WIDTH_MEM-1:0] VEC_STRIDE = 16'h0010
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_IRQ-1:0]        irq_i,
  input  logic [NUM_IRQ-1:0]        irq_mask_i,
  input  logic                      int_en_i,
  input  logic                      int_ack_i,
  input  logic                      iret_i,
  input  logic                      ctxt_rdy_i,
  output logic                      int_req_o,
  output logic [ID_WIDTH-1:0]       int_id_o,
  output logic                      int_set_o,
  output logic                      ret_valid_o,
  output logic                      vec_valid_o,
  output logic [ADDR_WIDTH_MEM-1:0] vec_addr_o,
  output logic                      ret_done_o,
  output logic [DEPTH_WIDTH-1:0]    depth_o,
  output logic                      busy_o,
  output logic                      err_unf_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PUSH,
    S_VEC,
    S_POP,
    S_WAIT_CTXT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_IRQ-1:0]       irq_q;
  logic [NUM_IRQ-1:0]       pend_q, pend_d;
  logic [DEPTH_WIDTH-1:0]   depth_q, depth_d;
  logic [ID_WIDTH-1:0]      int_id_q, int_id_d;
  logic                     err_unf_q, err_unf_d;
  logic [ID_WIDTH-1:0]      act_id_q [STACK_DEPTH];

  logic [ID_WIDTH-1:0]      top_id;
  logic                     room;
  logic [NUM_IRQ-1:0]       elig;
  logic                     any_elig;
  logic [ID_WIDTH-1:0]      sel_id;

  // Priority of the handler currently running (top of the active chain).
  // It only matters when depth > 0.
  always_comb begin
    top_id = '0;
    for (int l = 0; l < STACK_DEPTH; l++) begin
      if (depth_q == DEPTH_WIDTH'(l + 1)) top_id = act_id_q[l];
    end
  end

  assign room = (depth_q < DEPTH_WIDTH'(STACK_DEPTH));

  // A request is eligible only if it strictly outranks the running handler.
  // Equal or lower priority waits in pend until the returns unwind.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig[i] = pend_q[i] & ~irq_mask_i[i] & int_en_i & room &
                ((depth_q == '0) | (ID_WIDTH'(i) < top_id));
    end
  end

  // Lowest eligible index wins. Scanning downward lets the lowest index overwrite.
  always_comb begin
    any_elig = 1'b0;
    sel_id   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        any_elig = 1'b1;
        sel_id   = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    int_id_d  = int_id_q;
    err_unf_d = err_unf_q;
    pend_d    = pend_q;

    if (state_q == S_PUSH) pend_d[int_id_q] = 1'b0;
    // Edges are captured in every state.
    // A re-edge on a line that is already pending is simply absorbed.
    pend_d = pend_d | (irq_i & ~irq_q);

    case (state_q)
      S_IDLE: begin
        if (iret_i) begin
          if (depth_q == '0) begin
            err_unf_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d   = S_POP;
          end
        end else if (any_elig) begin
          int_id_d = sel_id;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // Once int_req is seen with int_ack, AP_ctrl has committed.
        // Only withdraw the offer when no ack is present.
        if (int_ack_i) begin
          state_d = S_PUSH;
        end else if (irq_mask_i[int_id_q] || !int_en_i) begin
          state_d = S_IDLE;
        end
      end
      S_PUSH: begin
        depth_d = depth_q + 1'b1;
        state_d = S_VEC;
      end
      S_VEC:       state_d = S_IDLE;
      S_POP: begin
        depth_d = depth_q - 1'b1;
        state_d = S_WAIT_CTXT;
      end
      S_WAIT_CTXT: if (ctxt_rdy_i) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      irq_q     <= '0;
      pend_q    <= '0;
      depth_q   <= '0;
      int_id_q  <= '0;
      err_unf_q <= 1'b0;
      for (int l = 0; l < STACK_DEPTH; l++) act_id_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_i;
      pend_q    <= pend_d;
      depth_q   <= depth_d;
      int_id_q  <= int_id_d;
      err_unf_q <= err_unf_d;
      for (int l = 0; l < STACK_DEPTH; l++) begin
        if (state_q == S_PUSH && depth_q == DEPTH_WIDTH'(l)) act_id_q[l] <= int_id_q;
      end
    end
  end

  // All outputs are state decodes or registers.
  // They go to 0 as soon as reset asserts.
  assign int_req_o   = (state_q == S_REQ);
  assign int_set_o   = (state_q == S_PUSH);
  assign vec_valid_o = (state_q == S_VEC);
  assign ret_valid_o = (state_q == S_POP);
  assign ret_done_o  = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign int_id_o    = int_id_q;
  assign depth_o     = depth_q;
  assign err_unf_o   = err_unf_q;
  // vec_addr is gated so it reads 0 outside the vector cycle, reset included.
  assign vec_addr_o  = vec_valid_o ?
                       (VEC_BASE + ADDR_WIDTH_MEM'(int_id_q) * VEC_STRIDE) : '0;

endmodule

// File: tb/tb_int_sched.sv
module tb_int_sched;
  localparam int NI = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] irq, irq_mask;
  logic          int_en, int_ack, iret, ctxt_rdy;
  logic          int_req, int_set, ret_valid, vec_valid, ret_done, busy, err_unf;
  logic [IW-1:0] int_id;
  logic [15:0]   vec_addr;
  logic [3:0]    depth;

  int total = 0;
  int bad   = 0;

  int_sched #(.NUM_IRQ(NI), .ID_WIDTH(IW), .STACK_DEPTH(8), .DEPTH_WIDTH(4),
              .ADDR_WIDTH_MEM(16), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010)) dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .irq_mask_i(irq_mask), .int_en_i(int_en),
    .int_ack_i(int_ack), .iret_i(iret), .ctxt_rdy_i(ctxt_rdy),
    .int_req_o(int_req), .int_id_o(int_id), .int_set_o(int_set), .ret_valid_o(ret_valid),
    .vec_valid_o(vec_valid), .vec_addr_o(vec_addr), .ret_done_o(ret_done),
    .depth_o(depth), .busy_o(busy), .err_unf_o(err_unf));

  always #5 clk = ~clk;

  // Inputs are driven and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    irq = '0; irq_mask = '0; int_ack = 0; iret = 0; ctxt_rdy = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic do_ret();
    iret = 1; tick(); iret = 0; tick();
    ctxt_rdy = 1; tick(); ctxt_rdy = 0; tick();
  endtask

  task automatic test_reset();
    rst_n = 0; irq = '0; irq_mask = '0; int_en = 1; int_ack = 0; iret = 0; ctxt_rdy = 0;
    tick(); tick();
    total++;
    if ({int_req, int_set, ret_valid, vec_valid, ret_done, busy, err_unf} !== 7'b0 ||
        int_id !== 4'd0 || vec_addr !== 16'h0 || depth !== 4'd0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b set=%b rv=%b vv=%b rd=%b busy=%b err=%b id=%0d va=%h depth=%0d, required all 0",
               int_req, int_set, ret_valid, vec_valid, ret_done, busy, err_unf, int_id, vec_addr, depth);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    irq[2] = 1; tick(); tick();
    total++;
    if (int_req !== 1 || int_id !== 4'd2) begin
      bad++; $display("FAIL single_offer: req=%b id=%0d, required req=1 id=2", int_req, int_id);
    end
    int_ack = 1; tick(); int_ack = 0;
    total++;
    if (int_set !== 1 || vec_valid !== 0) begin
      bad++; $display("FAIL single_push: set=%b vv=%b, required set=1 vv=0", int_set, vec_valid);
    end
    tick();
    total++;
    if (int_set !== 0 || vec_valid !== 1 || vec_addr !== 16'h0120 || depth !== 4'd1) begin
      bad++; $display("FAIL single_vec: set=%b vv=%b va=%h depth=%0d, required 0 1 0120 1",
                      int_set, vec_valid, vec_addr, depth);
    end
    tick();
    total++;
    if (vec_valid !== 0 || busy !== 0) begin
      bad++; $display("FAIL single_idle: vv=%b busy=%b, required 0 0", vec_valid, busy);
    end
  endtask

  task automatic test_nesting();
    irq[1] = 1; irq[3] = 1; tick(); tick();
    total++;
    if (int_req !== 1 || int_id !== 4'd1) begin
      bad++; $display("FAIL nest_offer: req=%b id=%0d, required req=1 id=1", int_req, int_id);
    end
    int_ack = 1; tick(); int_ack = 0; tick();
    total++;
    if (depth !== 4'd2) begin bad++; $display("FAIL nest_depth: depth=%0d, required 2", depth); end
    tick(); tick();
    total++;
    if (int_req !== 0) begin bad++; $display("FAIL nest_irq3_held: req=%b, required 0", int_req); end
    iret = 1; tick(); iret = 0;
    total++;
    if (ret_valid !== 1) begin bad++; $display("FAIL nest_pop: rv=%b, required 1", ret_valid); end
    tick();
    total++;
    if (ret_valid !== 0 || depth !== 4'd1) begin
      bad++; $display("FAIL nest_wait: rv=%b depth=%0d, required 0 1", ret_valid, depth);
    end
    ctxt_rdy = 1; tick(); ctxt_rdy = 0;
    total++;
    if (ret_done !== 1) begin bad++; $display("FAIL nest_done: rd=%b, required 1", ret_done); end
    tick(); tick();
    total++;
    if (int_req !== 0 || ret_done !== 0) begin
      bad++; $display("FAIL nest_irq3_still_held: req=%b rd=%b, required 0 0", int_req, ret_done);
    end
    iret = 1; tick(); iret = 0; tick();
    ctxt_rdy = 1; tick(); ctxt_rdy = 0;
    total++;
    if (depth !== 4'd0) begin bad++; $display("FAIL nest_depth0: depth=%0d, required 0", depth); end
    tick(); tick();
    total++;
    if (int_req !== 1 || int_id !== 4'd3) begin
      bad++; $display("FAIL nest_irq3_offer: req=%b id=%0d, required req=1 id=3", int_req, int_id);
    end
    int_ack = 1; tick(); int_ack = 0; tick(); tick();
  endtask

  task automatic test_iret_priority();
    irq = '0; tick();
    irq[0] = 1; tick();
    iret = 1; tick(); iret = 0;
    total++;
    if (ret_valid !== 1 || int_req !== 0) begin
      bad++; $display("FAIL iretpri_pop: rv=%b req=%b, required 1 0", ret_valid, int_req);
    end
    tick(); ctxt_rdy = 1; tick(); ctxt_rdy = 0; tick(); tick();
    total++;
    if (int_req !== 1 || int_id !== 4'd0) begin
      bad++; $display("FAIL iretpri_offer: req=%b id=%0d, required req=1 id=0", int_req, int_id);
    end
    int_ack = 1; tick(); int_ack = 0; tick();
    total++;
    if (vec_valid !== 1 || vec_addr !== 16'h0100) begin
      bad++; $display("FAIL iretpri_vec: vv=%b va=%h, required 1 0100", vec_valid, vec_addr);
    end
    tick();
  endtask

  task automatic test_full();
    logic [15:0] exp_va;
    do_ret();
    irq = '0; tick();
    for (int k = 8; k >= 1; k--) begin
      irq[k] = 1; tick(); tick();
      total++;
      if (int_req !== 1 || int_id !== IW'(k)) begin
        bad++; $display("FAIL full_offer_%0d: req=%b id=%0d, required req=1 id=%0d", k, int_req, int_id, k);
      end
      int_ack = 1; tick(); int_ack = 0; tick();
      exp_va = 16'h0100 + 16'(k) * 16'h0010;
      total++;
      if (vec_addr !== exp_va) begin
        bad++; $display("FAIL full_vec_%0d: va=%h, required %h", k, vec_addr, exp_va);
      end
      tick();
    end
    total++;
    if (depth !== 4'd8) begin bad++; $display("FAIL full_depth8: depth=%0d, required 8", depth); end
    irq[0] = 1; tick(); tick(); tick();
    total++;
    if (int_req !== 0 || busy !== 0) begin
      bad++; $display("FAIL full_blocked: req=%b busy=%b, required 0 0", int_req, busy);
    end
    iret = 1; tick(); iret = 0; tick();
    total++;
    if (depth !== 4'd7) begin bad++; $display("FAIL full_depth7: depth=%0d, required 7", depth); end
    ctxt_rdy = 1; tick(); ctxt_rdy = 0; tick(); tick();
    total++;
    if (int_req !== 1 || int_id !== 4'd0) begin
      bad++; $display("FAIL full_served: req=%b id=%0d, required req=1 id=0", int_req, int_id);
    end
    do_reset();
  endtask

  task automatic test_underflow();
    iret = 1; tick(); iret = 0;
    total++;
    if (ret_done !== 1 || err_unf !== 1 || ret_valid !== 0) begin
      bad++; $display("FAIL unf_done: rd=%b err=%b rv=%b, required 1 1 0", ret_done, err_unf, ret_valid);
    end
    tick(); tick();
    total++;
    if (ret_done !== 0 || err_unf !== 1 || ret_valid !== 0 || depth !== 4'd0) begin
      bad++; $display("FAIL unf_sticky: rd=%b err=%b rv=%b depth=%0d, required 0 1 0 0",
                      ret_done, err_unf, ret_valid, depth);
    end
  endtask

  task automatic test_mask_and_reset();
    irq[3] = 1; tick(); tick();
    total++;
    if (int_req !== 1 || int_id !== 4'd3) begin
      bad++; $display("FAIL mask_offer: req=%b id=%0d, required req=1 id=3", int_req, int_id);
    end
    irq_mask[3] = 1; tick();
    total++;
    if (int_req !== 0 || busy !== 0) begin
      bad++; $display("FAIL mask_drop: req=%b busy=%b, required 0 0", int_req, busy);
    end
    tick();
    total++;
    if (int_req !== 0) begin bad++; $display("FAIL mask_held: req=%b, required 0", int_req); end
    irq_mask[3] = 0; tick();
    total++;
    if (int_req !== 1 || int_id !== 4'd3) begin
      bad++; $display("FAIL mask_reoffer: req=%b id=%0d, required req=1 id=3", int_req, int_id);
    end
    int_ack = 1; tick(); int_ack = 0; tick(); tick();
    iret = 1; tick(); iret = 0; tick();
    total++;
    if (busy !== 1 || ret_valid !== 0) begin
      bad++; $display("FAIL mid_wait: busy=%b rv=%b, required 1 0", busy, ret_valid);
    end
    #1 rst_n = 0;
    #1;
    total++;
    if ({int_req, int_set, ret_valid, vec_valid, ret_done, busy, err_unf} !== 7'b0 ||
        int_id !== 4'd0 || vec_addr !== 16'h0 || depth !== 4'd0) begin
      bad++;
      $display("FAIL midreset_outputs: req=%b set=%b rv=%b vv=%b rd=%b busy=%b err=%b id=%0d va=%h depth=%0d, required all 0",
               int_req, int_set, ret_valid, vec_valid, ret_done, busy, err_unf, int_id, vec_addr, depth);
    end
    irq = '0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_nesting();
    test_iret_priority();
    test_full();
    test_underflow();
    test_mask_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
